// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: state, transfer-size and grant encodings shared by mem_ctrl and mem_arbiter.
package mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  typedef enum logic {GNT_INST, GNT_DATA} gnt_t;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  // Index of the final byte of a transfer; the reserved size code 11 behaves as a word.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    return size == SZ_BYTE ? 2'd0 : size == SZ_HALF ? 2'd1 : 2'd3;
  endfunction
endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: CPU fetch/data request ports plus the byte-wide RAM bus of mem_ctrl.
interface mem_ctrl_if #(
  parameter int LEN = 32,
  parameter int ADDR_WIDTH = 17
) ();
  logic rdy_in;
  logic busy;
  logic inst_req;
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic [LEN-1:0] inst_data;
  logic inst_done;
  logic data_req;
  logic data_we;
  logic [1:0] data_size;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [LEN-1:0] data_wdata;
  logic [LEN-1:0] data_rdata;
  logic data_done;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic ram_wr;
  modport slave (
    input rdy_in, inst_req, inst_addr, data_req, data_we, data_size, data_addr, data_wdata, ram_din,
    output busy, inst_data, inst_done, data_rdata, data_done, ram_dout, ram_addr, ram_wr
  );
  modport master (
    output rdy_in, inst_req, inst_addr, data_req, data_we, data_size, data_addr, data_wdata, ram_din,
    input busy, inst_data, inst_done, data_rdata, data_done, ram_dout, ram_addr, ram_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: grant selection between fetch and data ports, and the last-grant register.
// MEM_CTRL_ROUND_ROBIN_EN alternates on contention; otherwise the data port always wins.
module mem_arbiter import mem_ctrl_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic inst_req,
  input  logic data_req,
  input  logic accept,
  output gnt_t grant,
  output gnt_t owner
);
  gnt_t owner_q, owner_d;
`ifdef MEM_CTRL_ROUND_ROBIN_EN
  always_comb grant = inst_req && data_req ? (owner_q == GNT_INST ? GNT_DATA : GNT_INST)
                                           : (data_req ? GNT_DATA : GNT_INST);
`else
  always_comb grant = inst_req && !data_req ? GNT_INST : GNT_DATA;
`endif
  always_comb owner_d = accept ? grant : owner_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) owner_q <= GNT_INST;
    else owner_q <= owner_d;
  assign owner = owner_q;
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises fetch and data word accesses into byte transfers on a synchronous RAM.
// Optional round-robin contention handling via MEM_CTRL_ROUND_ROBIN_EN (inside mem_arbiter).
module mem_ctrl import mem_ctrl_pkg::*; #(
  parameter int LEN = 32,
  parameter int ADDR_WIDTH = 17
) (
  input logic clk,
  input logic rst,
  mem_ctrl_if.slave bus
);
  state_t state_q, state_d;
  gnt_t grant, owner;
  logic accept, is_data, is_read;
  logic [1:0] cnt_q, cnt_d, last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN-1:0] wdata_q, wdata_d, buf_q, buf_d;
  logic [LEN-1:0] inst_data_q, inst_data_d, data_rdata_q, data_rdata_d;
  logic [7:0] dout_q, dout_d;
  logic wr_q, wr_d, inst_done_q, inst_done_d, data_done_q, data_done_d, busy_q, busy_d;

  assign accept = state_q == IDLE && bus.rdy_in && (bus.inst_req || bus.data_req);
  assign is_data = grant == GNT_DATA;
  assign is_read = state_q == READ;

  mem_arbiter u_arb (
    .clk      (clk),
    .rst      (rst),
    .inst_req (bus.inst_req),
    .data_req (bus.data_req),
    .accept   (accept),
    .grant    (grant),
    .owner    (owner)
  );

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    buf_d = buf_q;
    dout_d = dout_q;
    wr_d = wr_q;
    inst_data_d = inst_data_q;
    data_rdata_d = data_rdata_q;
    inst_done_d = 1'b0;
    data_done_d = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d = is_data && bus.data_we ? WRITE : READ;
        cnt_d = 2'd0;
        last_d = is_data ? last_idx(bus.data_size) : last_idx(SZ_WORD);
        addr_d = is_data ? bus.data_addr : bus.inst_addr;
        wdata_d = bus.data_wdata;
        buf_d = '0;
        wr_d = is_data && bus.data_we;
        dout_d = bus.data_wdata[7:0];
      end
      READ, WRITE: begin
        // ram_din at this edge is the byte addressed during the cycle just ending
        if (is_read) buf_d[8*cnt_q +: 8] = bus.ram_din;
        if (cnt_q == last_q) begin
          state_d = DONE;
          wr_d = 1'b0;
          inst_done_d = owner == GNT_INST;
          data_done_d = owner == GNT_DATA;
          inst_data_d = is_read && owner == GNT_INST ? buf_d : inst_data_q;
          data_rdata_d = is_read && owner == GNT_DATA ? buf_d : data_rdata_q;
        end else begin
          cnt_d = cnt_q + 2'd1;
          addr_d = addr_q + 1'b1;
          dout_d = wdata_q[8*cnt_d +: 8];
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      buf_q <= '0;
      dout_q <= '0;
      wr_q <= 1'b0;
      inst_data_q <= '0;
      data_rdata_q <= '0;
      inst_done_q <= 1'b0;
      data_done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      buf_q <= buf_d;
      dout_q <= dout_d;
      wr_q <= wr_d;
      inst_data_q <= inst_data_d;
      data_rdata_q <= data_rdata_d;
      inst_done_q <= inst_done_d;
      data_done_q <= data_done_d;
      busy_q <= busy_d;
    end

  assign bus.busy = busy_q;
  assign bus.inst_data = inst_data_q;
  assign bus.inst_done = inst_done_q;
  assign bus.data_rdata = data_rdata_q;
  assign bus.data_done = data_done_q;
  assign bus.ram_dout = dout_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_wr = wr_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized and directed checks of mem_ctrl against a byte-array memory model.
module tb_mem_ctrl;
  localparam int LEN = 32;
  localparam int AW = 17;
  localparam int MSZ = 1 << AW;
`ifdef MEM_CTRL_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_ctrl_if #(.LEN(LEN), .ADDR_WIDTH(AW)) bus ();
  mem_ctrl #(.LEN(LEN), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] ram [MSZ];
  logic [7:0] ref_mem [MSZ];
  logic [LEN-1:0] exp_inst = '0;
  logic [LEN-1:0] exp_data = '0;
  bit last_data = 1'b0;
  int n_tests = 0;
  int n_fail = 0;

  // RAM answers half a cycle after the address so the byte is stable at the next rising edge
  always @(negedge clk) bus.ram_din <= ram[bus.ram_addr];
  always @(posedge clk) if (bus.ram_wr) ram[bus.ram_addr] <= bus.ram_dout;

  function automatic logic [LEN-1:0] ref_read(input int addr, input int n);
    logic [LEN-1:0] r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = ref_mem[(addr + k) % MSZ];
    return r;
  endfunction

  task automatic poke(input int addr, input logic [7:0] v);
    ram[addr] <= v;
    ref_mem[addr] = v;
  endtask

  task automatic idle_inputs();
    bus.rdy_in = 1'b1;
    bus.inst_req = 1'b0;
    bus.data_req = 1'b0;
    bus.inst_addr = '0;
    bus.data_addr = '0;
    bus.data_we = 1'b0;
    bus.data_size = 2'b10;
    bus.data_wdata = '0;
  endtask

  task automatic run_txn(input bit is_data, input bit we, input logic [1:0] size,
                         input logic [AW-1:0] addr, input logic [LEN-1:0] wdata,
                         input int stall, input int drop_at, input string name);
    int n, c, wr_cnt;
    bit ok_wr;
    logic [LEN-1:0] exp;
    n = !is_data ? 4 : size == 2'b00 ? 1 : size == 2'b01 ? 2 : 4;
    exp = ref_read(int'(addr), n);
    @(negedge clk);
    bus.inst_req = !is_data;
    bus.data_req = is_data;
    bus.inst_addr = addr;
    bus.data_addr = addr;
    bus.data_we = we;
    bus.data_size = size;
    bus.data_wdata = wdata;
    bus.rdy_in = stall == 0;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      n_tests++;
      if (bus.busy !== 1'b0 || bus.inst_done !== 1'b0 || bus.data_done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s stall: busy=%b done=%b%b, required 0 00", name, bus.busy, bus.inst_done, bus.data_done);
      end
    end
    if (stall > 0) begin
      @(negedge clk);
      bus.rdy_in = 1'b1;
    end
    @(posedge clk); #1;
    last_data = is_data;
    bus.inst_addr = AW'($urandom);
    bus.data_addr = AW'($urandom);
    bus.data_wdata = $urandom;
    bus.data_size = 2'($urandom);
    c = 0;
    wr_cnt = 0;
    ok_wr = 1'b1;
    while (c <= 12) begin
      if (c == drop_at) bus.rdy_in = 1'b0;
      if (bus.ram_wr) begin
        wr_cnt++;
        if (c >= n || bus.ram_addr !== AW'((int'(addr) + c) % MSZ) || bus.ram_dout !== wdata[8*c +: 8]) ok_wr = 1'b0;
      end
      if (bus.inst_done || bus.data_done) break;
      @(posedge clk); #1;
      c++;
    end
    bus.inst_req = 1'b0;
    bus.data_req = 1'b0;
    bus.rdy_in = 1'b1;
    n_tests++;
    if (c != n) begin
      n_fail++;
      $display("FAIL %s latency: done after %0d cycles, required %0d", name, c, n);
    end
    n_tests++;
    if ({bus.inst_done, bus.data_done} !== {!is_data, is_data}) begin
      n_fail++;
      $display("FAIL %s done port: inst/data=%b%b, required %b%b", name, bus.inst_done, bus.data_done, !is_data, is_data);
    end
    n_tests++;
    if (wr_cnt != ((is_data && we) ? n : 0) || !ok_wr) begin
      n_fail++;
      $display("FAIL %s ram writes: count=%0d ok=%b, required count=%0d ok=1", name, wr_cnt, ok_wr, (is_data && we) ? n : 0);
    end
    if (is_data && we) for (int k = 0; k < n; k++) ref_mem[(int'(addr) + k) % MSZ] = wdata[8*k +: 8];
    else if (is_data) exp_data = exp;
    else exp_inst = exp;
    n_tests++;
    if (bus.inst_data !== exp_inst || bus.data_rdata !== exp_data) begin
      n_fail++;
      $display("FAIL %s read data: inst=%h data=%h, required inst=%h data=%h", name, bus.inst_data, bus.data_rdata, exp_inst, exp_data);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus.inst_done || bus.data_done || bus.busy || bus.ram_wr) begin
      n_fail++;
      $display("FAIL %s after done: done=%b%b busy=%b wr=%b, required all 0", name, bus.inst_done, bus.data_done, bus.busy, bus.ram_wr);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.ram_wr !== 1'b0 || bus.inst_done !== 1'b0 || bus.data_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset flags: busy=%b wr=%b done=%b%b, required 0", bus.busy, bus.ram_wr, bus.inst_done, bus.data_done);
    end
    n_tests++;
    if (bus.ram_addr !== '0 || bus.ram_dout !== '0 || bus.inst_data !== '0 || bus.data_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset values: addr=%h dout=%h inst=%h data=%h, required 0", bus.ram_addr, bus.ram_dout, bus.inst_data, bus.data_rdata);
    end
    @(negedge clk);
    rst = 1'b1;
    last_data = 1'b0;
  endtask

  task automatic test_fetch();
    poke(32'h100, 8'h11);
    poke(32'h101, 8'h22);
    poke(32'h102, 8'h33);
    poke(32'h103, 8'h44);
    run_txn(1'b0, 1'b0, 2'b10, 17'h00100, '0, 0, -1, "fetch");
    n_tests++;
    if (bus.inst_data !== 32'h44332211) begin
      n_fail++;
      $display("FAIL fetch word: got %h, required 44332211", bus.inst_data);
    end
  endtask

  task automatic test_store_byte();
    run_txn(1'b1, 1'b1, 2'b00, 17'h00203, 32'hDEADBEAB, 0, -1, "store_byte");
    n_tests++;
    if (ram[32'h203] !== 8'hAB || ram[32'h204] !== ref_mem[32'h204]) begin
      n_fail++;
      $display("FAIL store_byte ram: got %h/%h, required AB/%h", ram[32'h203], ram[32'h204], ref_mem[32'h204]);
    end
  endtask

  task automatic test_wrap();
    poke(MSZ - 1, 8'h7F);
    poke(0, 8'h80);
    run_txn(1'b1, 1'b0, 2'b01, 17'h1FFFF, '0, 0, -1, "wrap_half");
    n_tests++;
    if (bus.data_rdata !== 32'h0000807F) begin
      n_fail++;
      $display("FAIL wrap_half value: got %h, required 0000807f", bus.data_rdata);
    end
    run_txn(1'b1, 1'b1, 2'b10, 17'h1FFFE, 32'hCAFEF00D, 0, -1, "wrap_store");
    run_txn(1'b0, 1'b0, 2'b10, 17'h1FFFE, '0, 0, -1, "wrap_fetch");
  endtask

  task automatic test_rdy();
    run_txn(1'b1, 1'b0, 2'b10, 17'h00300, '0, 3, 1, "rdy_load");
    run_txn(1'b0, 1'b0, 2'b10, 17'h00400, '0, 2, 0, "rdy_fetch");
  endtask

  task automatic test_contention();
    int c;
    bit exp_d;
    logic [LEN-1:0] v;
    @(negedge clk);
    bus.rdy_in = 1'b1;
    bus.inst_req = 1'b1;
    bus.data_req = 1'b1;
    bus.inst_addr = 17'h00500;
    bus.data_addr = 17'h00600;
    bus.data_we = 1'b0;
    bus.data_size = 2'b10;
    for (int t = 0; t < 3; t++) begin
      exp_d = RR ? !last_data : 1'b1;
      c = 0;
      do begin
        @(posedge clk); #1;
        c++;
      end while (!bus.inst_done && !bus.data_done && c < 12);
      last_data = exp_d;
      v = ref_read(exp_d ? 32'h600 : 32'h500, 4);
      if (exp_d) exp_data = v;
      else exp_inst = v;
      n_tests++;
      if ({bus.inst_done, bus.data_done} !== {!exp_d, exp_d}) begin
        n_fail++;
        $display("FAIL contention grant %0d: inst/data done=%b%b, required %b%b", t, bus.inst_done, bus.data_done, !exp_d, exp_d);
      end
      n_tests++;
      if (bus.inst_data !== exp_inst || bus.data_rdata !== exp_data) begin
        n_fail++;
        $display("FAIL contention data %0d: inst=%h data=%h, required %h %h", t, bus.inst_data, bus.data_rdata, exp_inst, exp_data);
      end
    end
    bus.inst_req = 1'b0;
    bus.data_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_write();
    logic [LEN-1:0] w;
    w = $urandom;
    @(negedge clk);
    bus.data_req = 1'b1;
    bus.data_we = 1'b1;
    bus.data_size = 2'b10;
    bus.data_addr = 17'h00700;
    bus.data_wdata = w;
    bus.rdy_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_tests++;
    if (bus.ram_wr !== 1'b1 || bus.ram_addr !== 17'h00701 || bus.ram_dout !== w[15:8]) begin
      n_fail++;
      $display("FAIL abort precondition: wr=%b addr=%h dout=%h, required 1 00701 %h", bus.ram_wr, bus.ram_addr, bus.ram_dout, w[15:8]);
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (bus.ram_wr !== 1'b0 || bus.busy !== 1'b0 || bus.data_done !== 1'b0 || bus.ram_addr !== '0) begin
      n_fail++;
      $display("FAIL abort async: wr=%b busy=%b done=%b addr=%h, required 0 0 0 0", bus.ram_wr, bus.busy, bus.data_done, bus.ram_addr);
    end
    ref_mem[32'h700] = w[7:0];
    exp_inst = '0;
    exp_data = '0;
    last_data = 1'b0;
    bus.data_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (bus.data_done !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort residue: done=%b busy=%b, required 0 0", bus.data_done, bus.busy);
      end
    end
    run_txn(1'b1, 1'b0, 2'b10, 17'h00700, '0, 0, -1, "after_abort");
  endtask

  task automatic test_random();
    bit d, we;
    logic [AW-1:0] a;
    for (int i = 0; i < 40; i++) begin
      d = 1'($urandom_range(0, 1));
      we = d && 1'($urandom_range(0, 1));
      a = $urandom_range(0, 3) == 0 ? AW'($urandom_range(MSZ - 4, MSZ - 1)) : AW'($urandom_range(0, 255));
      run_txn(d, we, 2'($urandom), a, $urandom, 0, -1, "random");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MSZ; i++) begin
      ref_mem[i] = 8'($urandom);
      ram[i] <= ref_mem[i];
    end
    test_reset();
    test_fetch();
    test_store_byte();
    test_wrap();
    test_rdy();
    test_contention();
    test_reset_mid_write();
    test_contention();
    test_random();
    test_contention();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
